// File: rtl/trigger_capture_if.sv
// Control, sample and read-port bundle between the capture stage and its
// surroundings (trigger detector, ADC front end, software read port).
interface trigger_capture_if #(
  parameter int ADC_WIDTH = 12,
  parameter int AW        = 10
);
  logic                 MOD_ENABLED;
  logic                 ARM;
  logic                 SAMPLE_EN;
  logic [ADC_WIDTH-1:0] ADC_DATA;
  logic                 TRIGGED;
  logic                 TRIG_EDGE;
  logic [31:0]          USER_PRE;
  logic                 RD_EN;
  logic [AW-1:0]        RD_ADDR;
  logic [ADC_WIDTH-1:0] RD_DATA;
  logic                 RD_VALID;
  logic                 BUSY;
  logic                 DONE;
  logic                 CAPT_EDGE;
  logic [AW-1:0]        TRIG_ADDR;

  modport master (
    output MOD_ENABLED, ARM, SAMPLE_EN, ADC_DATA, TRIGGED, TRIG_EDGE,
           USER_PRE, RD_EN, RD_ADDR,
    input  RD_DATA, RD_VALID, BUSY, DONE, CAPT_EDGE, TRIG_ADDR
  );

  modport slave (
    input  MOD_ENABLED, ARM, SAMPLE_EN, ADC_DATA, TRIGGED, TRIG_EDGE,
           USER_PRE, RD_EN, RD_ADDR,
    output RD_DATA, RD_VALID, BUSY, DONE, CAPT_EDGE, TRIG_ADDR
  );
endinterface

// File: rtl/trigger_capture.sv
// Pre/post-trigger capture: circular sample buffer frozen a fixed number of
// samples after a trigger rise, read back oldest-first through a linear port.
module trigger_capture #(
  parameter int ADC_WIDTH = 12,
  parameter int DEPTH     = 1024,
  parameter int AW        = 10
) (
  input logic              CLK,
  input logic              RST,
  trigger_capture_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_FILL,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [AW:0]  DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [31:0]  PRE_MAX = 32'(DEPTH - 1);

  state_t               state, state_nxt;
  logic [AW-1:0]        wr_ptr;
  logic [AW:0]          cnt;
  logic [AW:0]          cnt_inc;
  logic [AW-1:0]        pre_eff;
  logic [AW-1:0]        pre_arm;
  logic [AW:0]          post_len;
  logic                 trig_q;
  logic                 trig_rise;
  logic [AW-1:0]        trig_addr;
  logic                 capt_edge;
  logic                 write_state;
  logic                 wr_en;
  logic                 arm_ok;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        phys;
  logic                 rd_fire;
  logic [ADC_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  logic [ADC_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  assign pre_arm     = (bus.USER_PRE > PRE_MAX) ? AW'(PRE_MAX) : bus.USER_PRE[AW-1:0];
  assign post_len    = DEPTH_W - {1'b0, pre_eff};
  assign cnt_inc     = cnt + 1'b1;
  assign trig_rise   = bus.TRIGGED & ~trig_q;
  assign write_state = (state == S_PRE_FILL) || (state == S_ARMED) || (state == S_POST);
  assign wr_en       = write_state & bus.SAMPLE_EN & bus.MOD_ENABLED;
  assign arm_ok      = bus.ARM & bus.MOD_ENABLED & ((state == S_IDLE) || (state == S_DONE));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps this block purely combinational;
  // any path that left state_nxt unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    if (!bus.MOD_ENABLED) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (bus.ARM) state_nxt = S_PRE_FILL;
        // Pre-count is checked before this cycle's write is counted.
        S_PRE_FILL:     if (cnt == {1'b0, pre_eff}) state_nxt = S_ARMED;
        // With a single post sample, a write in the trigger cycle ends the frame.
        S_ARMED: begin
          if (trig_rise) state_nxt = (wr_en && post_len == (AW+1)'(1)) ? S_DONE : S_POST;
        end
        S_POST:         if (wr_en && cnt_inc == post_len) state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_PRE_FILL, S_ARMED, S_POST: busy = 1'b1;
      S_DONE:                      done = 1'b1;
      default:                     ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write pointer, sample counter and trigger bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      cnt       <= '0;
      pre_eff   <= '0;
      trig_addr <= '0;
      capt_edge <= 1'b0;
    end else if (arm_ok) begin
      wr_ptr  <= '0;
      cnt     <= '0;
      pre_eff <= pre_arm;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        S_PRE_FILL, S_POST: if (wr_en) cnt <= cnt_inc;
        S_ARMED: begin
          if (trig_rise) begin
            trig_addr <= wr_ptr;
            capt_edge <= bus.TRIG_EDGE;
            cnt       <= {{AW{1'b0}}, wr_en};
          end
        end
        default: ;
      endcase
    end
  end

  // Registered every cycle so a level already high at arm time is never a rise.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) trig_q <= 1'b0;
    else      trig_q <= bus.TRIGGED;
  end

  // ---------------------------------------------------------------------------
  // Sample buffer
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; a reset port would prevent block-RAM
  // inference, and stale contents are never readable outside a fresh frame.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= bus.ADC_DATA;
  end

  // Frame index 0 is pre_eff samples before the trigger sample.
  assign phys    = trig_addr - pre_eff + bus.RD_ADDR;
  assign rd_fire = bus.RD_EN & (state == S_DONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= mem[phys];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.BUSY      = busy;
  assign bus.DONE      = done;
  assign bus.CAPT_EDGE = capt_edge;
  assign bus.TRIG_ADDR = trig_addr;
  assign bus.RD_DATA   = rd_data;
  assign bus.RD_VALID  = rd_valid;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture (DEPTH=16): capture, stale trigger,
// pre-count boundaries, wrap with gaps, abort/re-arm, async reset.
module tb_trigger_capture;

  localparam int ADC_WIDTH = 12;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ramp    = 0;

  always #5 clk = ~clk;

  trigger_capture_if #(.ADC_WIDTH(ADC_WIDTH), .AW(AW)) bus ();

  trigger_capture #(
    .ADC_WIDTH(ADC_WIDTH),
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int pre);
    bus.USER_PRE = pre;
    bus.ARM      = 1'b1;
    tick();
    bus.ARM      = 1'b0;
  endtask

  // One sample per cycle.
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      bus.SAMPLE_EN = 1'b1;
      bus.ADC_DATA  = ADC_WIDTH'(ramp);
      tick();
      ramp++;
    end
    bus.SAMPLE_EN = 1'b0;
  endtask

  // Sample cycle followed by a gap cycle carrying junk data.
  task automatic feed_gap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.SAMPLE_EN = 1'b1;
      bus.ADC_DATA  = ADC_WIDTH'(ramp);
      tick();
      ramp++;
      bus.SAMPLE_EN = 1'b0;
      bus.ADC_DATA  = 12'hABC;
      tick();
    end
  endtask

  task automatic read_one(input string tag, input int addr, input int exp);
    bus.RD_EN   = 1'b1;
    bus.RD_ADDR = AW'(addr);
    tick();
    bus.RD_EN   = 1'b0;
    check({tag, "_valid"}, 32'(bus.RD_VALID), 32'd1);
    check({tag, "_data"}, 32'(bus.RD_DATA), 32'(exp));
  endtask

  // Back-to-back reads of the whole frame, expecting base, base+1, ...
  task automatic read_all(input string tag, input int base);
    for (int i = 0; i < DEPTH; i++) begin
      bus.RD_EN   = 1'b1;
      bus.RD_ADDR = AW'(i);
      tick();
      check($sformatf("%s_v%0d", tag, i), 32'(bus.RD_VALID), 32'd1);
      check($sformatf("%s_d%0d", tag, i), 32'(bus.RD_DATA), 32'(base + i));
    end
    bus.RD_EN = 1'b0;
    tick();
    check({tag, "_valid_drop"}, 32'(bus.RD_VALID), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.MOD_ENABLED = 1'b0;
    bus.ARM         = 1'b0;
    bus.SAMPLE_EN   = 1'b0;
    bus.ADC_DATA    = '0;
    bus.TRIGGED     = 1'b0;
    bus.TRIG_EDGE   = 1'b0;
    bus.USER_PRE    = '0;
    bus.RD_EN       = 1'b0;
    bus.RD_ADDR     = '0;

    // Reset values
    #1 rst = 1'b0;
    #2;
    check("rst_busy",      32'(bus.BUSY),      32'd0);
    check("rst_done",      32'(bus.DONE),      32'd0);
    check("rst_capt_edge", 32'(bus.CAPT_EDGE), 32'd0);
    check("rst_trig_addr", 32'(bus.TRIG_ADDR), 32'd0);
    check("rst_rd_valid",  32'(bus.RD_VALID),  32'd0);
    check("rst_rd_data",   32'(bus.RD_DATA),   32'd0);
    #19 rst = 1'b1;
    tick();
    bus.MOD_ENABLED = 1'b1;
    tick();

    // Basic capture: pre 4, trigger at sample 20, frame 16..31
    bus.TRIG_EDGE = 1'b1;
    arm(4);
    check("basic_busy_arm", 32'(bus.BUSY), 32'd1);
    ramp = 0;
    feed(20);
    bus.TRIGGED = 1'b1;
    feed(1);
    feed(10);
    check("basic_not_done", 32'(bus.DONE), 32'd0);
    check("basic_busy_post", 32'(bus.BUSY), 32'd1);
    feed(1);
    check("basic_done",      32'(bus.DONE),      32'd1);
    check("basic_busy_off",  32'(bus.BUSY),      32'd0);
    check("basic_capt_edge", 32'(bus.CAPT_EDGE), 32'd1);
    check("basic_trig_addr", 32'(bus.TRIG_ADDR), 32'd4);
    read_all("basic", 16);

    // Stale trigger level: held high across ARM, then a real falling-edge trigger
    arm(4);
    check("stale_done_clr", 32'(bus.DONE), 32'd0);
    ramp = 100;
    feed(30);
    check("stale_busy", 32'(bus.BUSY), 32'd1);
    check("stale_done", 32'(bus.DONE), 32'd0);
    bus.TRIGGED = 1'b0;
    feed(2);
    bus.TRIGGED   = 1'b1;
    bus.TRIG_EDGE = 1'b0;
    feed(1);
    feed(10);
    check("stale_not_done", 32'(bus.DONE), 32'd0);
    feed(1);
    check("stale_done_set",  32'(bus.DONE),      32'd1);
    check("stale_capt_edge", 32'(bus.CAPT_EDGE), 32'd0);
    read_one("stale_a0", 0, 128);
    read_one("stale_a4", 4, 132);
    read_one("stale_a15", 15, 143);

    // Pre count 0: frame index 0 is the trigger sample
    bus.TRIGGED   = 1'b0;
    bus.TRIG_EDGE = 1'b1;
    arm(0);
    check("pre0_done_clr", 32'(bus.DONE), 32'd0);
    ramp = 200;
    feed(3);
    bus.TRIGGED = 1'b1;
    feed(1);
    feed(14);
    check("pre0_not_done", 32'(bus.DONE), 32'd0);
    feed(1);
    check("pre0_done",      32'(bus.DONE),      32'd1);
    check("pre0_trig_addr", 32'(bus.TRIG_ADDR), 32'd3);
    read_one("pre0_a0", 0, 203);
    read_one("pre0_a15", 15, 218);

    // Pre count clamped to DEPTH-1: the trigger sample is the only post sample
    bus.TRIGGED = 1'b0;
    arm(100);
    ramp = 300;
    feed(20);
    check("clamp_busy", 32'(bus.BUSY), 32'd1);
    bus.TRIGGED = 1'b1;
    feed(1);
    check("clamp_done",      32'(bus.DONE),      32'd1);
    check("clamp_busy_off",  32'(bus.BUSY),      32'd0);
    check("clamp_trig_addr", 32'(bus.TRIG_ADDR), 32'd4);
    read_one("clamp_a0", 0, 305);
    read_one("clamp_a14", 14, 319);
    read_one("clamp_a15", 15, 320);

    // Wrap with gaps: 60 sampled cycles in ARMED, junk on every gap cycle
    bus.TRIGGED = 1'b0;
    arm(3);
    ramp = 400;
    feed_gap(60);
    check("wrap_busy", 32'(bus.BUSY), 32'd1);
    check("wrap_done", 32'(bus.DONE), 32'd0);
    bus.TRIGGED = 1'b1;
    feed_gap(1);
    feed_gap(11);
    check("wrap_not_done", 32'(bus.DONE), 32'd0);
    feed_gap(1);
    check("wrap_done_set",  32'(bus.DONE),      32'd1);
    check("wrap_trig_addr", 32'(bus.TRIG_ADDR), 32'd12);
    read_all("wrap", 457);

    // ARM during POST is ignored
    bus.TRIGGED = 1'b0;
    arm(3);
    ramp = 500;
    feed(10);
    bus.TRIGGED = 1'b1;
    feed(1);
    bus.ARM = 1'b1;
    feed(1);
    bus.ARM = 1'b0;
    check("armpost_busy", 32'(bus.BUSY), 32'd1);
    feed(10);
    check("armpost_not_done", 32'(bus.DONE), 32'd0);
    feed(1);
    check("armpost_done", 32'(bus.DONE), 32'd1);
    read_one("armpost_a0", 0, 507);
    read_one("armpost_a3", 3, 510);

    // MOD_ENABLED low during POST, then reads in IDLE are rejected
    bus.TRIGGED = 1'b0;
    arm(3);
    ramp = 600;
    feed(8);
    bus.TRIGGED = 1'b1;
    feed(1);
    feed(2);
    check("dis_busy_post", 32'(bus.BUSY), 32'd1);
    bus.MOD_ENABLED = 1'b0;
    tick();
    check("dis_busy", 32'(bus.BUSY), 32'd0);
    check("dis_done", 32'(bus.DONE), 32'd0);
    bus.RD_EN   = 1'b1;
    bus.RD_ADDR = '0;
    tick();
    check("idle_rd_valid0", 32'(bus.RD_VALID), 32'd0);
    tick();
    check("idle_rd_valid1", 32'(bus.RD_VALID), 32'd0);
    bus.RD_EN       = 1'b0;
    bus.MOD_ENABLED = 1'b1;
    tick();

    // Async reset mid-POST, asserted between clock edges
    bus.TRIGGED = 1'b0;
    arm(3);
    ramp = 700;
    feed(8);
    bus.TRIGGED = 1'b1;
    feed(1);
    feed(2);
    check("ar_trig_addr_pre", 32'(bus.TRIG_ADDR), 32'd8);
    check("ar_capt_edge_pre", 32'(bus.CAPT_EDGE), 32'd1);
    check("ar_rd_data_pre",   32'(bus.RD_DATA),   32'd510);
    rst = 1'b0;
    #2;
    check("ar_busy",      32'(bus.BUSY),      32'd0);
    check("ar_done",      32'(bus.DONE),      32'd0);
    check("ar_capt_edge", 32'(bus.CAPT_EDGE), 32'd0);
    check("ar_trig_addr", 32'(bus.TRIG_ADDR), 32'd0);
    check("ar_rd_valid",  32'(bus.RD_VALID),  32'd0);
    check("ar_rd_data",   32'(bus.RD_DATA),   32'd0);
    #1 rst = 1'b1;
    tick();
    check("ar_idle_busy", 32'(bus.BUSY), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
# trigger_capture

Pre/post-trigger sample capture stage that sits directly downstream of the derivative trigger detector. Writes the ADC sample stream into a circular buffer continuously once armed, freezes it a fixed number of samples after the detector's `TRIGGED` rises, and records the trigger edge. Software then reads the frame oldest-first through a linear read port.

## Interface
**Parameters**
- `ADC_WIDTH`, default 12: ADC sample width.
- `DEPTH`, default 1024: buffer depth in samples, power of two.
- `AW`, default 10: address width, log2(`DEPTH`).

**Ports**
- `CLK` in 1: single clock; all logic on its rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `MOD_ENABLED` in 1: module enable; low forces IDLE synchronously.
- `ARM` in 1: one-cycle start pulse.
- `SAMPLE_EN` in 1: sample strobe; `ADC_DATA` is valid when high.
- `ADC_DATA` in `ADC_WIDTH`: ADC sample, same bus the trigger detector sees.
- `TRIGGED` in 1: trigger detector flag, level, held until the detector is re-enabled.
- `TRIG_EDGE` in 1: 1 = rising, 0 = falling; valid while `TRIGGED`.
- `USER_PRE` in 32: number of pre-trigger samples.
- `RD_EN` in 1: read request.
- `RD_ADDR` in `AW`: frame-relative index; 0 = oldest sample.
- `RD_DATA` out `ADC_WIDTH`: read data.
- `RD_VALID` out 1: `RD_DATA` valid.
- `BUSY` out 1: high in PRE_FILL, ARMED and POST.
- `DONE` out 1: frame frozen and readable.
- `CAPT_EDGE` out 1: latched `TRIG_EDGE` of the captured event.
- `TRIG_ADDR` out `AW`: physical buffer address of the trigger sample.

## Operation
- **Effective pre-trigger count:** `pre_eff` = min(`USER_PRE`, `DEPTH`-1), latched at `ARM`. Post count = `DEPTH` - `pre_eff`.
- **Write path:** in PRE_FILL, ARMED and POST, every `SAMPLE_EN` cycle writes `ADC_DATA` to `mem[wr_ptr]`. `wr_ptr` then increments modulo `DEPTH`, wrapping silently.
- **Trigger detection:** `trig_rise` = `TRIGGED` & ~`trig_q`, where `trig_q` is `TRIGGED` registered every cycle. A `TRIGGED` level that is already high is never a trigger.

**State machine**
- **IDLE:** no writes.
  - `ARM` -> PRE_FILL, with `wr_ptr`=0, `cnt`=0, `DONE`=0.
- **PRE_FILL:** `cnt` counts writes; `trig_rise` is ignored.
  - `cnt`==`pre_eff` -> ARMED, evaluated before the write of the current cycle. `pre_eff`=0 therefore passes through PRE_FILL for exactly one cycle.
- **ARMED:** keeps writing.
  - `trig_rise` -> POST.
  - On that cycle: `TRIG_ADDR` <= `wr_ptr`, `CAPT_EDGE` <= `TRIG_EDGE`, `cnt` <= 0.
  - A sample written in the trigger cycle is post-sample 0 and increments `cnt`.
- **POST:** `cnt` counts writes.
  - When the write that makes `cnt` == post count lands -> DONE. No further writes.
- **DONE:** buffer frozen; reads allowed.
  - `ARM` -> PRE_FILL, exactly as from IDLE.
- **ARM priority:** `ARM` in PRE_FILL, ARMED or POST is ignored.
- **MOD_ENABLED low:** in any state -> IDLE next cycle; `DONE`=0; `BUSY`=0; buffer contents undefined.
- **Read path:** `phys` = (`TRIG_ADDR` - `pre_eff` + `RD_ADDR`) mod `DEPTH`.
  - `RD_EN` in DONE returns `mem[phys]`.
  - `RD_EN` outside DONE gives `RD_VALID`=0.
- **Arithmetic:** all address arithmetic is `AW` bits, unsigned, wrapping.
- **Buffer:** single write port and single read port; infers block RAM.

## Timing
- **Reset values (async, `RST`=0):** state IDLE, `wr_ptr`=0, `cnt`=0, `trig_q`=0, `BUSY`=0, `DONE`=0, `CAPT_EDGE`=0, `TRIG_ADDR`=0, `RD_VALID`=0, `RD_DATA`=0.
- **Trigger latency:** `TRIGGED` rising at edge N is recognised at edge N+1, since `trig_q` lags by one. `TRIG_ADDR` therefore points at the sample written in the cycle the rise is seen.
- **Read latency:** `RD_EN` at edge N gives `RD_DATA`/`RD_VALID` at edge N+1. `RD_VALID` is a one-cycle pulse per request. Back-to-back reads give one result per cycle.
- **DONE assertion:** `DONE` rises the cycle after the final post-trigger write and stays high until `ARM`, `MOD_ENABLED` low, or reset.
- **BUSY:** `BUSY` falls in the same cycle `DONE` rises.
- **Frame length:** a full frame is exactly `DEPTH` samples. Samples older than `pre_eff` before the trigger are overwritten by post samples.

## Test plan
- **Basic capture** (`DEPTH`=16, `USER_PRE`=4, `SAMPLE_EN`=1, `ADC_DATA` = ramp 0,1,2,…): `ARM`, raise `TRIGGED` (`TRIG_EDGE`=1) at sample value 20 -> `DONE` after 12 post samples. Reading `RD_ADDR` 0..15 returns 16..31; `CAPT_EDGE`=1.
- **Stale trigger level:** `TRIGGED` held high before and during `ARM` -> state stays ARMED and no capture occurs. Drop `TRIGGED` low, then raise it with `TRIG_EDGE`=0 -> capture completes with `CAPT_EDGE`=0.
- **Boundary pre counts:**
  - `USER_PRE`=0 -> `RD_ADDR` 0 is the trigger sample.
  - `USER_PRE`=100 with `DEPTH`=16 -> clamped to 15; exactly one post sample is captured.
- **Wrap and gaps:** `SAMPLE_EN` toggling 1/0, long ARMED period (more than 3×`DEPTH` samples) -> frame still ordered oldest-first across the wrap; gap cycles write nothing.
- **Abort and re-arm:**
  - `MOD_ENABLED` low during POST -> IDLE, `DONE`=0.
  - `ARM` during POST -> ignored.
  - `ARM` in DONE -> new capture; `DONE` clears the next cycle.
- **Async reset and read gating:** `RST` low mid-POST -> all outputs at reset values immediately, with no clock edge required. `RD_EN` in IDLE -> `RD_VALID` stays 0.
